// File: rtl/hs_pkg.sv
// Shared types and helpers for the handshake merge family.
// State encoding, select-width helper and protocol constants.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OUT_REQ,
    RELEASE
  } hs_state_e;

  localparam int HS_PHASES = 4;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_rr_merge_if.sv
// Bundle of the N input channels, the output channel and the
// transfer counters of one round-robin merge.
interface hs_rr_merge_if #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int CW = 8,
  parameter int SW = hs_pkg::sel_w(N)
);

  logic [N-1:0]   in_req;
  logic [N-1:0]   in_ack;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   sink_mask;
  logic           out_req;
  logic           out_ack;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic [CW-1:0]  fwd_count;
  logic [CW-1:0]  drop_count;

  modport master (
    output in_req, in_data, sink_mask, out_ack,
    input  in_ack, out_req, out_data, out_src,
    input  fwd_count, drop_count
  );

  modport slave (
    input  in_req, in_data, sink_mask, out_ack,
    output in_ack, out_req, out_data, out_src,
    output fwd_count, drop_count
  );

endinterface

// File: rtl/hs_sync.sv
// Multi-bit flop synchroniser; STAGES=0 passes the input
// straight through.
module hs_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_ff
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++)
          sync_q[i] <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++)
          sync_q[i] <= sync_q[i-1];
      end
    end

    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/hs_rr_merge.sv
// N-to-1 four-phase round-robin merge with per-channel sink
// mask and forwarded/discarded transfer counters.
module hs_rr_merge
  import hs_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8
) (
  input logic         clk,
  input logic         rst,
  hs_rr_merge_if.slave bus
);

  localparam int SW = sel_w(N);

  logic [N-1:0] req_s;
  logic         ack_s;

  hs_sync #(
    .WIDTH (N),
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus.in_req),
    .q_o(req_s)
  );

  hs_sync #(
    .WIDTH (1),
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus.out_ack),
    .q_o(ack_s)
  );

  hs_state_e     state_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] sel_q;
  logic          drop_q;
  logic [N-1:0]  in_ack_q;
  logic          out_req_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;
  logic [CW-1:0] fwd_q;
  logic [CW-1:0] drop_cnt_q;

  logic [SW-1:0] win;
  logic          any;
  logic [SW-1:0] nxt;

  // Scan downward so the nearest set bit above ptr wins last.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req_s[idx]) begin
        win = SW'(idx);
        any = 1'b1;
      end
    end
  end

  assign nxt = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      drop_q     <= 1'b0;
      in_ack_q   <= '0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      fwd_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            out_data_q <= bus.in_data[int'(win)*W +: W];
            out_src_q  <= win;
            sel_q      <= win;
            drop_q     <= bus.sink_mask[win];
            if (bus.sink_mask[win]) begin
              in_ack_q[win] <= 1'b1;
              state_q       <= RELEASE;
            end else begin
              out_req_q <= 1'b1;
              state_q   <= OUT_REQ;
            end
          end
        end
        OUT_REQ: begin
          if (ack_s) begin
            out_req_q       <= 1'b0;
            in_ack_q[sel_q] <= 1'b1;
            state_q         <= RELEASE;
          end
        end
        RELEASE: begin
          if (!req_s[sel_q] && (drop_q || !ack_s)) begin
            in_ack_q <= '0;
            ptr_q    <= nxt;
            if (drop_q) drop_cnt_q <= drop_cnt_q + 1'b1;
            else        fwd_q      <= fwd_q + 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ack     = in_ack_q;
  assign bus.out_req    = out_req_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.fwd_count  = fwd_q;
  assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_hs_rr_merge.sv
// Directed bench for hs_rr_merge: grant latency, rotation,
// sink mask, async reset and counter wrap.
module tb_hs_rr_merge;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hs_rr_merge_if #(.N(4), .W(8), .CW(8)) b ();
  hs_rr_merge_if #(.N(4), .W(8), .CW(4)) b2 ();

  hs_rr_merge #(
    .N(4), .W(8), .SYNC_STAGES(2), .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  hs_rr_merge #(
    .N(4), .W(8), .SYNC_STAGES(2), .CW(4)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.in_req = '0;
    b.out_ack = 1'b0;
    b.sink_mask = '0;
    b.in_data = '0;
    b2.in_req = '0;
    b2.out_ack = 1'b0;
    b2.sink_mask = '0;
    b2.in_data = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_req(input bit lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (b.out_req === lvl) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_ack(input int ch, input bit lvl,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (b.in_ack[ch] === lvl) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic fwd_done(input int ch, output bit ok);
    bit o1, o2;
    b.out_ack = 1'b1;
    wait_ack(ch, 1'b1, o1);
    b.in_req[ch] = 1'b0;
    b.out_ack = 1'b0;
    wait_ack(ch, 1'b0, o2);
    ok = o1 & o2;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({b.in_ack, b.out_req, b.out_data, b.out_src} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %0h/%0b/%0h/%0h need 0",
               b.in_ack, b.out_req, b.out_data, b.out_src);
    end
    checks++;
    if ({b.fwd_count, b.drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d need 0/0",
               b.fwd_count, b.drop_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    b.in_data[16 +: 8] = 8'hA5;
    b.in_req[2] = 1'b1;
    repeat (2) step();
    checks++;
    if (b.out_req !== 1'b0) begin
      errors++;
      $display("FAIL single_early: out_req %b need 0", b.out_req);
    end
    step();
    checks++;
    if (b.out_req !== 1'b1) begin
      errors++;
      $display("FAIL single_lat: out_req %b need 1", b.out_req);
    end
    checks++;
    if (b.out_data !== 8'hA5 || b.out_src !== 2'd2) begin
      errors++;
      $display("FAIL single_data: got %0h src %0d need a5 src 2",
               b.out_data, b.out_src);
    end
    repeat (3) step();
    b.out_ack = 1'b1;
    repeat (2) step();
    checks++;
    if (b.in_ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_early: in_ack %b need 0000", b.in_ack);
    end
    step();
    checks++;
    if (b.in_ack !== 4'b0100 || b.out_req !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: in_ack %b out_req %b need 0100 0",
               b.in_ack, b.out_req);
    end
    b.in_req[2] = 1'b0;
    b.out_ack = 1'b0;
    repeat (2) step();
    checks++;
    if (b.in_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_hold: in_ack %b need 0100", b.in_ack);
    end
    step();
    checks++;
    if (b.in_ack !== 4'b0000 || b.fwd_count !== 8'd1) begin
      errors++;
      $display("FAIL single_done: in_ack %b fwd %0d need 0000 1",
               b.in_ack, b.fwd_count);
    end
  endtask

  task automatic test_rotation();
    int ord [5];
    bit ok;
    ord = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 4; c++)
      b.in_data[c*8 +: 8] = 8'h10 + 8'(c);
    b.in_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_req(1'b1, ok);
      checks++;
      if (!ok || b.out_src !== 2'(ord[i])
          || b.out_data !== 8'h10 + 8'(ord[i])) begin
        errors++;
        $display("FAIL rr_grant%0d: ok %b src %0d data %0h need %0d %0h",
                 i, ok, b.out_src, b.out_data, ord[i], 8'h10 + ord[i]);
      end
      fwd_done(ord[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_hs%0d: handshake timeout got 0 need 1", i);
      end
      if (i == 0) b.in_req[0] = 1'b1;
    end
    checks++;
    if (b.fwd_count !== 8'd5) begin
      errors++;
      $display("FAIL rr_count: fwd %0d need 5", b.fwd_count);
    end
  endtask

  task automatic test_sink();
    bit ok;
    do_reset();
    b.sink_mask = 4'b0010;
    b.in_data[8 +: 8] = 8'h11;
    b.in_data[24 +: 8] = 8'h33;
    b.in_req = 4'b1010;
    wait_ack(1, 1'b1, ok);
    checks++;
    if (!ok || b.out_req !== 1'b0 || b.in_ack !== 4'b0010) begin
      errors++;
      $display("FAIL sink_ack: ok %b out_req %b in_ack %b need 1 0 0010",
               ok, b.out_req, b.in_ack);
    end
    b.in_req[1] = 1'b0;
    wait_ack(1, 1'b0, ok);
    checks++;
    if (!ok || b.drop_count !== 8'd1 || b.fwd_count !== 8'd0) begin
      errors++;
      $display("FAIL sink_drop: ok %b drop %0d fwd %0d need 1 1 0",
               ok, b.drop_count, b.fwd_count);
    end
    wait_req(1'b1, ok);
    checks++;
    if (!ok || b.out_src !== 2'd3 || b.out_data !== 8'h33) begin
      errors++;
      $display("FAIL sink_fwd: ok %b src %0d data %0h need 1 3 33",
               ok, b.out_src, b.out_data);
    end
    fwd_done(3, ok);
    checks++;
    if (!ok || b.fwd_count !== 8'd1 || b.drop_count !== 8'd1) begin
      errors++;
      $display("FAIL sink_cnt: ok %b fwd %0d drop %0d need 1 1 1",
               ok, b.fwd_count, b.drop_count);
    end
  endtask

  task automatic test_mask_toggle();
    bit ok;
    do_reset();
    b.in_data[7:0] = 8'h5C;
    b.in_req[0] = 1'b1;
    wait_req(1'b1, ok);
    b.sink_mask = 4'b0001;
    repeat (4) step();
    b.sink_mask = 4'b0000;
    step();
    b.sink_mask = 4'b0001;
    checks++;
    if (!ok || b.out_req !== 1'b1 || b.in_ack !== 4'b0000) begin
      errors++;
      $display("FAIL mask_hold: ok %b out_req %b in_ack %b need 1 1 0000",
               ok, b.out_req, b.in_ack);
    end
    fwd_done(0, ok);
    checks++;
    if (!ok || b.fwd_count !== 8'd1 || b.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL mask_fwd: ok %b fwd %0d drop %0d need 1 1 0",
               ok, b.fwd_count, b.drop_count);
    end
    b.in_req[0] = 1'b1;
    wait_ack(0, 1'b1, ok);
    checks++;
    if (!ok || b.out_req !== 1'b0) begin
      errors++;
      $display("FAIL mask_next: ok %b out_req %b need 1 0",
               ok, b.out_req);
    end
    b.in_req[0] = 1'b0;
    wait_ack(0, 1'b0, ok);
    checks++;
    if (!ok || b.drop_count !== 8'd1) begin
      errors++;
      $display("FAIL mask_drop: ok %b drop %0d need 1 1",
               ok, b.drop_count);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    b.in_req[1] = 1'b1;
    wait_req(1'b1, ok);
    fwd_done(1, ok);
    b.in_req[1] = 1'b1;
    wait_req(1'b1, ok);
    b.out_ack = 1'b1;
    wait_ack(1, 1'b1, ok);
    checks++;
    if (!ok || b.fwd_count !== 8'd1) begin
      errors++;
      $display("FAIL arst_setup: ok %b fwd %0d need 1 1",
               ok, b.fwd_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b.in_ack !== 4'b0000 || b.out_req !== 1'b0
        || b.fwd_count !== 8'd0 || b.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL arst_clear: ack %b req %b fwd %0d drop %0d need 0",
               b.in_ack, b.out_req, b.fwd_count, b.drop_count);
    end
    step();
    rst = 1'b0;
    b.in_req = '0;
    b.out_ack = 1'b0;
    repeat (3) step();
    b.in_req = 4'b0101;
    wait_req(1'b1, ok);
    checks++;
    if (!ok || b.out_src !== 2'd0) begin
      errors++;
      $display("FAIL arst_ptr: ok %b src %0d need 1 0", ok, b.out_src);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    do_reset();
    all_ok = 1'b1;
    for (int t = 0; t < 17; t++) begin
      b2.in_req[0] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        if (b2.out_req === 1'b1) ok = 1'b1;
        else step();
      end
      all_ok &= ok;
      b2.out_ack = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        if (b2.in_ack[0] === 1'b1) ok = 1'b1;
        else step();
      end
      all_ok &= ok;
      b2.in_req[0] = 1'b0;
      b2.out_ack = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        if (b2.in_ack[0] === 1'b0) ok = 1'b1;
        else step();
      end
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || b2.fwd_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap: ok %b fwd %0d need 1 1",
               all_ok, b2.fwd_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_rotation();
    test_sink();
    test_mask_toggle();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_rr_merge.md
# hs_rr_merge

Parametrised, clocked successor to the two-input handshake merge/arbiter/swap_sink elements: merges N four-phase bundled-data input channels of width W onto one four-phase output channel. Arbitration is round-robin. A per-channel sink mask lets selected inputs be consumed and discarded instead of forwarded. Sits between hlatch pipeline stages wherever several producers feed one consumer, and replaces the fixed two-channel merge/swap_sink variants.

## Interface
- N, 4: input channel count, ≥2
- W, 1: data width per channel, ≥1
- SYNC_STAGES, 2: synchroniser flops on in_req and out_ack; 0 = sample directly
- CW, 8: width of each transfer counter
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_req  in  N  per-channel request
- in_ack  out  N  per-channel acknowledge
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- sink_mask  in  N  1 = discard channel i's token
- out_req  out  1  output request
- out_ack  in  1  output acknowledge
- out_data  out  W  registered data of the current token
- out_src  out  max(1,$clog2(N))  index of the channel that supplied out_data
- fwd_count  out  CW  completed forwarded transfers
- drop_count  out  CW  completed discarded transfers

## Operation
- Protocol is four-phase on every channel: req↑ (data stable) → ack↑ → req↓ → ack↓. in_data is bundled: it must be stable from in_req↑ until in_ack↑. Only in_req and out_ack are synchronised (req_s, ack_s).
- State machine with states IDLE, OUT_REQ, RELEASE:
  - IDLE: if any req_s[i] is set, the winner is the first set bit found searching upward from ptr, wrapping at N. On that edge: out_data←in_data[win], out_src←win, sel←win.
    - If sink_mask[win]=1: in_ack[win]←1 → RELEASE.
    - Otherwise: out_req←1 → OUT_REQ.
  - OUT_REQ: on ack_s=1: out_req←0, in_ack[sel]←1 → RELEASE.
  - RELEASE: wait for req_s[sel]=0 and (token discarded or ack_s=0). Then: in_ack[sel]←0, ptr←(sel+1) mod N, increment fwd_count or drop_count → IDLE.
- At most one in_ack bit is high at any time. in_ack[i] never rises unless the token was taken.
- sink_mask is sampled only at grant in IDLE. Changes mid-transfer do not affect the current token.
- out_data and out_src hold from grant until the next grant.
- Counters wrap modulo 2^CW without saturation.

## Timing
- Reset (async assert, synchronous deassert by the external reset tree):
  - in_ack=0, out_req=0, out_data=0, out_src=0, fwd_count=0, drop_count=0.
  - State IDLE, ptr=0, synchroniser flops cleared.
  - Reset mid-transfer abandons the token. Producers are required to restart their handshake.
- Grant latency:
  - out_req↑ (or in_ack↑ for a discarded token) at the (SYNC_STAGES+1)-th rising edge after in_req↑ is set up.
  - in_ack[sel]↑ at the (SYNC_STAGES+1)-th edge after out_ack↑.
  - in_ack↓ at the (SYNC_STAGES+1)-th edge after the last of in_req↓/out_ack↓.
- Minimum forwarded-token cycle, from IDLE back to IDLE: 3 FSM edges plus synchroniser delays.
- Simultaneous requests: one grant per IDLE visit. The others wait in rotation, so no channel waits more than N−1 tokens.
- A request from a channel that has just completed is not re-granted ahead of pending channels.

## Structure
- Shared package hs_pkg holds:
  - state enum (IDLE, OUT_REQ, RELEASE)
  - sel/out_src width helper function
  - the four-phase protocol constant used by the hlatch family
- Sub-module hs_sync: parametrised-width, SYNC_STAGES-deep flop synchroniser with async reset, instantiated for in_req (N bits) and out_ack (1 bit). Round-robin search stays in the top module.

## Test plan
- N=4, W=8, SYNC_STAGES=2: single request on ch2 with data 0xA5, consumer acks after 3 cycles → out_data=0xA5, out_src=2, out_req↑ 3 edges after in_req↑, fwd_count=1, in_ack[2] completes the four-phase handshake.
- All four channels request together with data 0x10..0x13, ptr=0 → served in order 0,1,2,3. Channel 0 re-requests immediately and is served only after ch3. fwd_count=5.
- sink_mask=4'b0010, ch1 and ch3 request → ch1 is discarded (out_req stays low, drop_count=1) before ch3 is forwarded (fwd_count=1).
- sink_mask toggles while ch0's token is in OUT_REQ → ch0 still forwarded. Mask applies from the next grant.
- rst pulsed while in RELEASE → in_ack and out_req are 0 within the same cycle with no clock edge needed; counters are 0; the next request is granted from ptr=0.
- CW=4: 17 forwarded transfers → fwd_count wraps to 1.
